ap_ctrl_hs_driver: RTL

- Synthesizable initiator for the ap_ctrl_hs block-level handshake: ap_start, ap_ready, ap_done, ap_continue.
- Issues a programmed number of transactions to one HLS kernel.
- Tracks in-flight starts and measures per-transaction latency and total run cycles.
- Drives a level `finish` flag; the dataflow monitor consumes it as its end-of-run signal.
- Sits in the sim/verification harness between the run controller and the DUT top.

---
 rtl/apctrl_drv_pkg.sv | 25 ++
 rtl/ap_ctrl_hs_driver_fifo.sv | 46 ++++
 rtl/ap_ctrl_hs_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/apctrl_drv_pkg.sv
// Shared types and helpers for the ap_ctrl_hs initiator: FSM states, default widths
// and the wrap-safe latency subtraction.
package apctrl_drv_pkg;

  localparam int DEF_CNT_W      = 32;
  localparam int DEF_TXN_W      = 16;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_CONT_STALL = 2;
  localparam int LAT_W          = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Unsigned subtraction; callers truncate to their counter width, which keeps
  // the result correct modulo 2^CNT_W when the timestamp wraps.
  function automatic logic [LAT_W-1:0] lat_sub(input logic [LAT_W-1:0] now,
                                               input logic [LAT_W-1:0] head);
    return now - head;
  endfunction

endpackage

// File: rtl/ap_ctrl_hs_driver_fifo.sv
// ap_ts_fifo: DEPTH x W circular buffer of start timestamps. Pointers carry one
// extra wrap bit so full and empty are distinguished without a counter.
module ap_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs initiator: issues cfg_num_txn starts to one kernel, times each one and
// raises a level finish flag. Optional APCTRL_DRV_CONT_THROTTLE_EN stalls ap_continue.
module ap_ctrl_hs_driver
  import apctrl_drv_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TXN_W = DEF_TXN_W,
  parameter int DEPTH = DEF_DEPTH
`ifdef APCTRL_DRV_CONT_THROTTLE_EN
  , parameter int CONT_STALL = DEF_CONT_STALL
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_go,
  input  logic [TXN_W-1:0] cfg_num_txn,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [TXN_W-1:0] txn_issued,
  output logic [TXN_W-1:0] txn_done,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic [CNT_W-1:0] total_cycles,
  output logic             err_protocol,
  output logic [1:0]       fsm_state
);

  // Handshake: a start is taken on ap_start & ap_ready; a completion on
  // ap_done & ap_continue. Neither side may assume the other holds a level
  // after the cycle in which both are high.

  state_t           state, state_n;
  logic [CNT_W-1:0] ts;
  logic [TXN_W-1:0] num;
  logic [CNT_W-1:0] head;
  logic [CNT_W-1:0] lat;
  logic             fifo_full, fifo_empty;
  logic             in_run, go_ok, accept, done_ack, complete, proto_err;

  assign in_run    = (state == ISSUE) || (state == DRAIN);
  assign go_ok     = cfg_go && (state == IDLE);
  assign ap_start  = (state == ISSUE) && !fifo_full;
  assign accept    = ap_start && ap_ready;
  assign done_ack  = ap_done && ap_continue;
  assign complete  = done_ack && in_run && !fifo_empty;
  assign proto_err = done_ack && (!in_run || fifo_empty);
  assign lat       = CNT_W'(lat_sub(LAT_W'(ts), LAT_W'(head)));
  assign busy      = in_run;
  assign fsm_state = state;

  ap_ts_fifo #(.DEPTH(DEPTH), .W(CNT_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .pop   (complete),
    .din   (ts),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (go_ok) state_n = (cfg_num_txn == '0) ? FINISH : ISSUE;
      ISSUE:  if (accept && (txn_issued + TXN_W'(1) == num)) state_n = DRAIN;
      DRAIN:  if (txn_done == num) state_n = FINISH;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts           <= '0;
      num          <= '0;
      txn_issued   <= '0;
      txn_done     <= '0;
      last_latency <= '0;
      max_latency  <= '0;
      total_cycles <= '0;
      err_protocol <= 1'b0;
      finish       <= 1'b0;
    end else begin
      ts <= ts + CNT_W'(1);
      if (go_ok) begin
        num          <= cfg_num_txn;
        txn_issued   <= '0;
        txn_done     <= '0;
        last_latency <= '0;
        max_latency  <= '0;
        total_cycles <= '0;
        err_protocol <= 1'b0;
        finish       <= 1'b0;
      end else begin
        if (accept) txn_issued <= txn_issued + TXN_W'(1);
        if (complete) begin
          txn_done     <= txn_done + TXN_W'(1);
          last_latency <= lat;
          if (lat > max_latency) max_latency <= lat;
        end
        if (proto_err)         err_protocol <= 1'b1;
        if (in_run)            total_cycles <= total_cycles + CNT_W'(1);
        if (state == FINISH)   finish       <= 1'b1;
      end
    end
  end

`ifdef APCTRL_DRV_CONT_THROTTLE_EN
  // Back-pressure the kernel for CONT_STALL cycles after every counted done.
  logic [2:0] stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              stall <= '0;
    else if (complete)      stall <= 3'(CONT_STALL);
    else if (stall != '0)   stall <= stall - 3'd1;
  end

  assign ap_continue = (stall == '0);
`else
  assign ap_continue = 1'b1;
`endif

endmodule
